// File: rtl/qbert_pkg.sv
// qbert_pkg: shared codes, FSM encodings and pyramid constants for the Q*bert jump controller.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package qbert_pkg;

  localparam int N_ROW_DEF = 7;
  localparam int N_CUBE    = 28;

  // Requested jump directions
  localparam logic [2:0] DIR_DR = 3'b001;
  localparam logic [2:0] DIR_DL = 3'b010;
  localparam logic [2:0] DIR_UR = 3'b011;
  localparam logic [2:0] DIR_UL = 3'b100;

  // Sprite-layer state encodings
  localparam logic [2:0] QB_START  = 3'b000;
  localparam logic [2:0] QB_JUMP   = 3'b001;
  localparam logic [2:0] QB_IDLE   = 3'b010;
  localparam logic [2:0] QB_SAUCER = 3'b011;
  localparam logic [2:0] QB_KO     = 3'b100;

  // Controller FSM
  typedef logic [2:0] fsm_t;
  localparam fsm_t ST_IDLE   = 3'd0;
  localparam fsm_t ST_ARM    = 3'd1;
  localparam fsm_t ST_MOVING = 3'd2;
  localparam fsm_t ST_COMMIT = 3'd3;
  localparam fsm_t ST_FALL   = 3'd4;
  localparam fsm_t ST_PAUSED = 3'd5;
  localparam fsm_t ST_WIN    = 3'd6;

  // Top cube, right edge (k = r) and left edge (k = 1) masks
  localparam logic [N_CUBE-1:0] TOP_OH   = 28'h0000001;
  localparam logic [N_CUBE-1:0] RSIDE_OH = 28'h8104225;
  localparam logic [N_CUBE-1:0] LSIDE_OH = 28'h020844B;

  function automatic logic dir_legal(input logic [2:0] d);
    return (d == DIR_DR) || (d == DIR_DL) || (d == DIR_UR) || (d == DIR_UL);
  endfunction

  // Cube index of (r, k): r(r-1)/2 + k - 1, row base taken from a table
  function automatic logic [4:0] cube_idx(input logic [2:0] r, input logic [2:0] k);
    logic [4:0] base;
    case (r)
      3'd2:    base = 5'd1;
      3'd3:    base = 5'd3;
      3'd4:    base = 5'd6;
      3'd5:    base = 5'd10;
      3'd6:    base = 5'd15;
      3'd7:    base = 5'd21;
      default: base = 5'd0;
    endcase
    return base + {2'b00, k} - 5'd1;
  endfunction

  function automatic logic [N_CUBE-1:0] cube_onehot(input logic [2:0] r, input logic [2:0] k);
    logic [N_CUBE-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    return one << cube_idx(r, k);
  endfunction

endpackage

// File: rtl/qbert_pyr_map.sv
// qbert_pyr_map: maps (row, col, direction) to the target cube and flags off-pyramid jumps.
// Latency: purely combinational.
// Backpressure: none.
module qbert_pyr_map
  import qbert_pkg::*;
#(
  parameter int N_ROW = N_ROW_DEF
) (
  input  logic [2:0]        r,
  input  logic [2:0]        k,
  input  logic [2:0]        dir,
  output logic [2:0]        nr,
  output logic [2:0]        nk,
  output logic [N_CUBE-1:0] tgt_oh,
  output logic              bad
);

  // Neighbour lookup; a bad target keeps the current r/k and yields an empty one-hot
  always_comb begin
    nr     = r;
    nk     = k;
    bad    = 1'b0;
    tgt_oh = '0;
    case (dir)
      DIR_DR: begin
        bad = (r == 3'(N_ROW));
        nr  = r + 3'd1;
      end
      DIR_DL: begin
        bad = (r == 3'(N_ROW));
        nr  = r + 3'd1;
        nk  = k + 3'd1;
      end
      DIR_UR: begin
        bad = (k == r);
        nr  = r - 3'd1;
      end
      DIR_UL: begin
        bad = (k == 3'd1);
        nr  = r - 3'd1;
        nk  = k - 3'd1;
      end
      default: ;
    endcase
    if (bad) begin
      nr = r;
      nk = k;
    end else begin
      tgt_oh = cube_onehot(nr, nk);
    end
  end

endmodule

// File: rtl/qbert_jump_ctrl.sv
// qbert_jump_ctrl: Q*bert jump sequencing, cube colouring and win/fall handling (QB_COLOR_TOGGLE_EN: commit toggles instead of sets).
// Latency: request registered one edge after dir_valid; position commits one edge after the done_move rising edge.
// Backpressure: requests outside IDLE (or with sprite not idle) are dropped; pause freezes the FSM and latches done_move edges.
module qbert_jump_ctrl
  import qbert_pkg::*;
#(
  parameter int N_ROW = N_ROW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        dir_req,
  input  logic              dir_valid,
  input  logic              e_start_qb,
  input  logic              e_pause_qb,
  input  logic              e_resume_qb,
  input  logic [2:0]        state_qb,
  input  logic              done_move,
  output logic [N_CUBE-1:0] position_qb,
  output logic [N_CUBE-1:0] e_next_qb,
  output logic [2:0]        e_jump_qb,
  output logic              e_bad_jump,
  output logic              e_win_qb,
  output logic [N_CUBE-1:0] cube_state
);

  fsm_t              st_q, saved_q;
  logic [2:0]        row_q, col_q, tgt_row_q, tgt_col_q;
  logic              done_q, done_pend_q, fall_start_q;
  logic [2:0]        m_row, m_col;
  logic [N_CUBE-1:0] m_oh, cs_nxt;
  logic              m_bad, done_rise;

  qbert_pyr_map #(.N_ROW(N_ROW)) u_map (
    .r      (row_q),
    .k      (col_q),
    .dir    (dir_req),
    .nr     (m_row),
    .nk     (m_col),
    .tgt_oh (m_oh),
    .bad    (m_bad)
  );

  assign done_rise = done_move & ~done_q;

`ifdef QB_COLOR_TOGGLE_EN
  assign cs_nxt = cube_state ^ e_next_qb;
`else
  assign cs_nxt = cube_state | e_next_qb;
`endif

  // Jump FSM: restart > pause > per-state behaviour
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q         <= ST_IDLE;
      saved_q      <= ST_IDLE;
      row_q        <= 3'd1;
      col_q        <= 3'd1;
      tgt_row_q    <= 3'd1;
      tgt_col_q    <= 3'd1;
      done_q       <= 1'b0;
      done_pend_q  <= 1'b0;
      fall_start_q <= 1'b0;
      position_qb  <= TOP_OH;
      e_next_qb    <= TOP_OH;
      cube_state   <= TOP_OH;
      e_jump_qb    <= 3'b000;
      e_bad_jump   <= 1'b0;
      e_win_qb     <= 1'b0;
    end else begin
      done_q <= done_move;
      if (e_start_qb && (st_q == ST_PAUSED || st_q == ST_WIN)) begin
        st_q         <= ST_IDLE;
        row_q        <= 3'd1;
        col_q        <= 3'd1;
        position_qb  <= TOP_OH;
        e_next_qb    <= TOP_OH;
        cube_state   <= TOP_OH;
        e_bad_jump   <= 1'b0;
        e_win_qb     <= 1'b0;
        done_pend_q  <= 1'b0;
        fall_start_q <= 1'b0;
      end else if (e_pause_qb && st_q != ST_WIN && st_q != ST_PAUSED) begin
        saved_q <= st_q;
        st_q    <= ST_PAUSED;
        // A landing that coincides with the pause must not be lost
        if (st_q == ST_MOVING && done_rise) done_pend_q <= 1'b1;
      end else begin
        case (st_q)
          ST_IDLE: begin
            if (dir_valid && dir_legal(dir_req) && state_qb == QB_IDLE) begin
              e_jump_qb  <= dir_req;
              e_next_qb  <= m_oh;
              e_bad_jump <= m_bad;
              tgt_row_q  <= m_row;
              tgt_col_q  <= m_col;
              st_q       <= ST_ARM;
            end
          end
          ST_ARM: begin
            if (state_qb != QB_IDLE) st_q <= ST_MOVING;
          end
          ST_MOVING: begin
            if (done_rise || done_pend_q) begin
              done_pend_q  <= 1'b0;
              fall_start_q <= 1'b0;
              st_q         <= e_bad_jump ? ST_FALL : ST_COMMIT;
            end
          end
          ST_COMMIT: begin
            row_q       <= tgt_row_q;
            col_q       <= tgt_col_q;
            position_qb <= e_next_qb;
            cube_state  <= cs_nxt;
            if (&cs_nxt) begin
              e_win_qb <= 1'b1;
              st_q     <= ST_WIN;
            end else begin
              st_q <= ST_IDLE;
            end
          end
          ST_FALL: begin
            if (!fall_start_q) begin
              if (state_qb == QB_START) fall_start_q <= 1'b1;
            end else if (state_qb == QB_IDLE) begin
              row_q        <= 3'd1;
              col_q        <= 3'd1;
              position_qb  <= TOP_OH;
              e_next_qb    <= TOP_OH;
              e_bad_jump   <= 1'b0;
              fall_start_q <= 1'b0;
              st_q         <= ST_IDLE;
            end
          end
          ST_PAUSED: begin
            if (done_rise && saved_q == ST_MOVING) done_pend_q <= 1'b1;
            if (e_resume_qb) st_q <= saved_q;
          end
          ST_WIN: ;
          default: st_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/qbert_jump_ctrl.md
QBERT_JUMP_CTRL -- requirements
Module: qbert_jump_ctrl

Interface
REQ-001 Parameter: N_ROW, default 7, pyramid row count; N_CUBE = N_ROW*(N_ROW+1)/2 = 28 is a fixed derived constant.
REQ-002 clk  input  1  single system clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 dir_req  input  3  requested direction: 001 DOWN_RIGHT, 010 DOWN_LEFT, 011 UP_RIGHT, 100 UP_LEFT; any other code is ignored.
REQ-005 dir_valid  input  1  one-cycle strobe qualifying dir_req.
REQ-006 e_start_qb / e_pause_qb / e_resume_qb  input  1 each  game restart, pause and resume pulses.
REQ-007 state_qb  input  3  sprite-layer state: 000 START, 001 JUMP, 010 IDLE, 011 SAUCER, 100 KO.
REQ-008 done_move  input  1  sprite-layer move-complete flag.
REQ-009 position_qb  output  28  one-hot current cube; bit 0 is the top cube.
REQ-010 e_next_qb  output  28  one-hot target cube; all zero when the target is off the pyramid.
REQ-011 e_jump_qb  output  3  direction of the jump in progress or last jump.
REQ-012 e_bad_jump / e_win_qb  output  1 each  off-pyramid jump flag and level-complete flag.
REQ-013 cube_state  output  28  per-cube "coloured" bits.

Function
REQ-014 Position is held internally as row r (1..7) and column k (1..r); cube index is r(r-1)/2+k-1, and position_qb is the one-hot of that index.
REQ-015 Targets: DOWN_RIGHT goes to (r+1,k); DOWN_LEFT goes to (r+1,k+1); UP_RIGHT goes to (r-1,k); UP_LEFT goes to (r-1,k-1).
REQ-016 A target is bad when it leaves the pyramid: a down move with r=7, UP_RIGHT with k=r, or UP_LEFT with k=1.
REQ-017 FSM states: IDLE, ARM, MOVING, COMMIT, FALL, PAUSED, WIN.
REQ-018 IDLE: dir_valid with a legal code and state_qb=IDLE -> on the next edge register e_jump_qb and e_next_qb, set e_bad_jump when the target is bad, and go to ARM; requests in every other state are dropped.
REQ-019 ARM: wait for state_qb≠IDLE -> MOVING; position_qb and e_next_qb remain unequal throughout ARM.
REQ-020 MOVING: rising edge of done_move (registered previous value 0, current value 1) -> COMMIT if the jump is good, FALL if it is bad.
REQ-021 COMMIT (one cycle): position ← target; set the target's cube_state bit; if cube_state becomes all ones, assert e_win_qb and go to WIN; otherwise go to IDLE.
REQ-022 FALL: wait for state_qb=START, then state_qb=IDLE; then position ← top cube, e_next_qb ← top cube, clear e_bad_jump, and go to IDLE.
REQ-023 e_jump_qb holds its last value after a jump; it is not cleared.
REQ-024 e_pause_qb in any state except WIN -> PAUSED, saving the prior state; e_resume_qb returns to the saved state; e_start_qb in PAUSED acts as a restart.
REQ-025 Restart (e_start_qb in PAUSED or WIN): position, e_next_qb ← top cube; cube_state ← bit 0 only; e_bad_jump, e_win_qb ← 0; state ← IDLE.
REQ-026 Priority when events coincide: e_start_qb > e_pause_qb > dir_valid; done_move arriving during PAUSED is recorded and acted on after resume.

Reset
REQ-027 Asynchronous assert: state IDLE, r=1, k=1, position_qb = e_next_qb = 28'h1, cube_state = 28'h1, e_jump_qb = 0, e_bad_jump = 0, e_win_qb = 0.
REQ-028 Reset asserted mid-jump abandons the move with no partial position update; deassertion is synchronised by the surrounding system.

Configuration
REQ-029 Macro QB_COLOR_TOGGLE_EN: when defined, COMMIT toggles the target's cube_state bit; when undefined, COMMIT only sets the bit.

Structure
REQ-030 Shared package qbert_pkg holds: direction codes, state_qb encodings, the FSM typedef, N_CUBE, and the TOP/Rside/Lside one-hot constants.
REQ-031 Sub-module qbert_pyr_map: purely combinational; takes (r, k, dir) and returns the target r/k, the one-hot target, and the bad flag.

Verification
REQ-032 Reset, then DOWN_LEFT with state_qb=IDLE -> next cycle e_next_qb=28'h4 and e_jump_qb=010; state_qb=JUMP then a done_move pulse -> position_qb=28'h4 and cube_state=28'h5.
REQ-033 At the top cube, UP_LEFT -> e_bad_jump=1 and e_next_qb=0; on done_move, then state_qb START then IDLE -> position_qb=28'h1 and e_bad_jump=0.
REQ-034 dir_valid while in MOVING or with state_qb=SAUCER -> e_jump_qb and e_next_qb are unchanged.
REQ-035 Visit all 28 cubes -> e_win_qb=1 on the final COMMIT; later dir_valid is ignored; e_start_qb -> cube_state=28'h1 and e_win_qb=0.
REQ-036 e_pause_qb during MOVING, then a done_move pulse, then e_resume_qb -> the commit happens after resume; with QB_COLOR_TOGGLE_EN, re-landing on cube 3 clears bit 2.
